// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default sizes for the
// two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_DEPTH = 6501;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: two-way grant selection; the priority
// pointer is owned by the caller.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = pointer ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer in front of the
// single-port data memory, with programmable wait states.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W =
        (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] DEPTH =
        ADDR_W'(MEM_DEPTH);

    arb_state_e        state;
    arb_state_e        state_n;
    logic              ptr;
    logic              owner;
    logic [CNT_W-1:0]  cnt;
    dmem_req_t         lat;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [1:0]        grant;
    logic              hs;
    logic              sel;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic              last;

    rr_arbiter2 u_rr (
        .req     ({req1_valid, req0_valid}),
        .enable  (state == IDLE),
        .pointer (ptr),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign hs         = |grant;
    assign sel        = grant[1];
    assign sel_write  = sel ? req1_write : req0_write;
    assign sel_addr   = sel ? req1_addr  : req0_addr;
    assign sel_wdata  = sel ? req1_wdata : req0_wdata;
    assign sel_err    = sel_addr >= DEPTH;
    assign last       = cnt == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Store strobe only on the last held cycle: one write edge.
    always_comb begin
        state_n        = state;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        rsp0_valid     = 1'b0;
        rsp1_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                if (hs) state_n = sel_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_address    = ADDR_W'(lat.addr);
                mem_write_data = DATA_W'(lat.wdata);
                mem_read       = !lat.write;
                mem_write      = lat.write && last;
                if (last) state_n = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            cnt     <= '0;
            lat     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (hs) begin
            ptr       <= ~sel;
            owner     <= sel;
            lat.write <= sel_write;
            lat.addr  <= DEF_ADDR_W'(sel_addr);
            lat.wdata <= DEF_DATA_W'(sel_wdata);
            cnt       <= sel_err ? '0 : CNT_INIT;
            err_q     <= sel_err;
            rdata_q   <= '0;
        end else if (state == ACCESS) begin
            if (!last)
                cnt <= cnt - CNT_W'(1);
            else if (!lat.write)
                rdata_q <= mem_read_data;
        end
    end

    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port, round-robin arbiter and sequencer in front of the single-port data memory. It accepts load/store requests from two requesters over valid/ready handshakes: port 0 is the MEM stage and port 1 is the debug/DMA loader. It serialises the requests onto the memory's `address`/`write_data`/`mem_read`/`mem_write` pins and inserts a programmable number of wait states. Each requester receives a one-cycle response carrying read data or an out-of-range error.

## Interface
- `ADDR_W`, 32, request/memory address width
- `DATA_W`, 32, data width
- `MEM_DEPTH`, 6501, number of valid memory words; addresses ≥ `MEM_DEPTH` are errors
- `WAIT_CYCLES`, 2, extra cycles the memory pins are held per access (≥ 0)
- `clk` input 1: sole clock, rising edge
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset)
- `req0_valid` / `req1_valid` input 1: request present; must hold with stable payload until ready
- `req0_ready` / `req1_ready` output 1: request accepted this cycle
- `req0_write` / `req1_write` input 1: 1 = store, 0 = load
- `req0_addr` / `req1_addr` input `ADDR_W`: word address
- `req0_wdata` / `req1_wdata` input `DATA_W`: store data
- `rsp0_valid` / `rsp1_valid` output 1: one-cycle response pulse; no backpressure
- `rsp0_rdata` / `rsp1_rdata` output `DATA_W`: load data; 0 for stores and errors
- `rsp0_err` / `rsp1_err` output 1: address out of range
- `mem_address` output `ADDR_W`: memory address
- `mem_write_data` output `DATA_W`: memory write data
- `mem_read` output 1: memory read enable
- `mem_write` output 1: memory write enable
- `mem_read_data` input `DATA_W`: memory read data (combinational from the memory)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - The grant goes to the single valid requester. If both are valid, it goes to the requester the priority pointer names.
  - `reqN_ready` = (state == IDLE) && grant == N. It is combinational and never asserted for both ports at once.
  - On handshake, the block latches the owner, write flag, addr and wdata, and flips the pointer to the other port.
  - If addr ≥ `MEM_DEPTH`, the FSM goes to RESP with err = 1 and no memory access. Otherwise it goes to ACCESS with the wait counter at `WAIT_CYCLES`.
- **ACCESS:**
  - `mem_address`/`mem_write_data` are driven from the latched values. `mem_read` = !write for every ACCESS cycle.
  - `mem_write` = write only on the final ACCESS cycle (counter == 0), giving exactly one write edge per store.
  - The counter decrements each cycle. On counter == 0, the block captures `mem_read_data` (loads) into the rdata register and goes to RESP.
- **RESP:**
  - `rspN_valid` = 1 for the owner only. `rspN_rdata`/`rspN_err` come from the registers.
  - The FSM returns to IDLE next cycle. A new request can be accepted no earlier than the following IDLE cycle.
- Outside ACCESS, `mem_read` = `mem_write` = 0 and `mem_address`/`mem_write_data` = 0.
- Response data/err outputs read 0 whenever the corresponding `rsp_valid` = 0.
- A request whose valid drops before ready is simply not taken; there is no error.

## Timing
- Reset values (`rst` = 0, asynchronous): state IDLE, pointer = port 0, counter 0, all `rsp*`/`mem_*` outputs 0.
  - `req*_ready` follows the combinational rule, so it may go high in reset-released IDLE.
- Handshake in cycle N:
  - ACCESS occupies cycles N+1 … N+1+`WAIT_CYCLES`.
  - `rsp_valid` is in cycle N+2+`WAIT_CYCLES`.
  - The next handshake is possible at N+3+`WAIT_CYCLES`.
- Error request: handshake in N, `rsp_valid` with err = 1 in N+1.
- Sustained throughput is one access per `WAIT_CYCLES`+3 cycles. Under contention, the ports strictly alternate.
- When `WAIT_CYCLES` = 0, ACCESS lasts one cycle and carries both `mem_read`/`mem_write` and the capture.
- Reset asserted mid-ACCESS: `mem_write` drops immediately, the transaction is dropped, and no response is issued.
- The counter width is $clog2(`WAIT_CYCLES`+1), with a minimum of 1.

## Structure
- Package `dmem_arb_pkg`: FSM state enum (IDLE/ACCESS/RESP), default `ADDR_W`/`DATA_W`/`MEM_DEPTH` constants, and a `dmem_req_t` struct (write, addr, wdata) used for the latched request.
- Sub-module `rr_arbiter2`:
  - Inputs: req[1:0], enable, pointer.
  - Outputs: a one-hot grant.
  - The pointer register lives in the parent.

## Test plan
- **Single store then load:** port 0 stores 0xDEADBEEF at 1000, then loads 1000, with `WAIT_CYCLES` = 2.
  - `mem_write` is high for exactly one cycle (N+3).
  - The load response arrives at N+4 with rdata = 0xDEADBEEF and err = 0.
- **Simultaneous requests from reset:** both ports request a load at 1004/1008.
  - Port 0 is granted first.
  - Port 1 is granted at the next IDLE.
  - Responses arrive 5 cycles apart.
- **Fairness:** both ports are held continuously valid for 6 requests. Grants alternate 0,1,0,1,0,1 and neither port is starved.
- **Out of range:** port 1 loads address 6501. `rsp1_valid` comes one cycle after the handshake with err = 1 and rdata = 0, and `mem_read`/`mem_write` never assert.
- **Reset mid-access:** `rst` is pulled low during the second ACCESS cycle of a store to 1012.
  - All outputs go to 0 immediately and no response is issued.
  - Memory[1012] is unchanged.
- **Zero wait states:** with `WAIT_CYCLES` = 0, a load of 1016 (pre-written with 7) responds 2 cycles after the handshake with rdata = 7.
